gomoku_match_ctrl: RTL and testbench

- Parametrised next-generation game controller for the N×N gomoku board.
- Sequences power-up flicker, board clear, move entry, judging and board write, like the current controller.
- Adds a per-move countdown with turn forfeit, per-side win scores, best-of match termination and alternating first player per round.
- Sits between the keyboard, the board-state RAM write port, the mem-reset block, the judger and the LED/buzzer outputs; it instantiates none of them.

---
 rtl/gomoku_match_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_gomoku_match_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gomoku_match_ctrl.sv
// Gomoku match controller: power-up flicker, board clear, move entry with a
// per-move countdown, judging, board write, round scoring and best-of match end.
module gomoku_match_ctrl #(
  parameter int EDGE_BITS  = 3,
  parameter int MOVE_TIME  = 15,
  parameter int CD_BITS    = 4,
  parameter int MATCH_WINS = 3,
  parameter int SCORE_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_power,
  input  logic                   btn_reset,
  input  logic                   btn_ok,
  input  logic                   sec_tick,
  input  logic                   flicker_tick,
  input  logic                   key_valid,
  input  logic [EDGE_BITS:0]     key_index,
  output logic                   key_ready,
  output logic                   memrst_en,
  input  logic                   memrst_done,
  output logic                   judge_en,
  input  logic                   judge_done,
  input  logic [1:0]             judge_result,
  output logic                   ram_we,
  output logic [2*EDGE_BITS-1:0] ram_wr_addr,
  output logic [1:0]             ram_wr_data,
  output logic [2*EDGE_BITS-1:0] pos,
  output logic                   cur_side,
  output logic                   point_flicker_en,
  output logic                   screen_flicker_en,
  output logic [CD_BITS-1:0]     countdown,
  output logic [SCORE_BITS-1:0]  red_wins,
  output logic [SCORE_BITS-1:0]  green_wins,
  output logic                   buzzer_en,
  output logic [2:0]             state_o
);

  localparam int POS_BITS = 2 * EDGE_BITS;
  localparam int CNT_BITS = 2 * EDGE_BITS + 1;
  localparam logic [CNT_BITS-1:0]   LAST_CELL    = CNT_BITS'((1 << POS_BITS) - 1);
  localparam logic [CD_BITS-1:0]    CD_RELOAD    = CD_BITS'(MOVE_TIME);
  localparam logic [SCORE_BITS-1:0] SCORE_MAX    = '1;
  localparam logic [SCORE_BITS-1:0] SCORE_TARGET = SCORE_BITS'(MATCH_WINS);

  typedef enum logic [2:0] {
    STOPPED   = 3'd0,
    STARTING  = 3'd1,
    CLEARING  = 3'd2,
    WAIT      = 3'd3,
    JUDGE     = 3'd4,
    WRITE     = 3'd5,
    ROUND_END = 3'd6,
    MATCH_END = 3'd7
  } state_t;

  state_t                state, state_next;
  logic [1:0]            btn_sync;
  logic                  btn_prev;
  logic [1:0]            flick_cnt;
  logic [EDGE_BITS-1:0]  pos_x, pos_y;
  logic                  x_set, y_set;
  logic                  first_side;
  logic                  win_flag;
  logic [CNT_BITS-1:0]   piece_cnt;

  logic btn_rise;
  logic run;
  logic timeout;
  logic key_accept;
  logic both_set;
  logic match_over;

  assign btn_rise   = btn_sync[1] & ~btn_prev;
  assign run        = sw_power & ~btn_reset;
  assign timeout    = (state == WAIT) && sec_tick && (countdown == '0);
  assign key_accept = run && (state == WAIT) && key_valid && !timeout;
  assign both_set   = x_set & y_set;
  assign match_over = (red_wins == SCORE_TARGET) || (green_wins == SCORE_TARGET);

  assign pos              = {pos_y, pos_x};
  assign point_flicker_en = (state == WAIT) && both_set;
  assign state_o          = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STOPPED;
    else        state <= state_next;
  end

  // Next-state and state-decoded outputs; power and reset-game override last.
  always_comb begin
    state_next        = state;
    memrst_en         = 1'b0;
    judge_en          = 1'b0;
    ram_we            = 1'b0;
    ram_wr_addr       = '0;
    ram_wr_data       = 2'b00;
    screen_flicker_en = 1'b0;
    buzzer_en         = 1'b0;
    case (state)
      STOPPED: begin
        if (sw_power) state_next = STARTING;
      end
      STARTING: begin
        screen_flicker_en = 1'b1;
        if (flicker_tick && flick_cnt == 2'd2) state_next = CLEARING;
      end
      CLEARING: begin
        memrst_en = 1'b1;
        if (memrst_done) state_next = WAIT;
      end
      WAIT: begin
        if (!timeout && btn_rise && both_set) state_next = JUDGE;
      end
      JUDGE: begin
        judge_en = 1'b1;
        if (judge_done) state_next = (judge_result == 2'b01) ? WAIT : WRITE;
      end
      WRITE: begin
        ram_we      = 1'b1;
        ram_wr_addr = pos;
        ram_wr_data = cur_side ? 2'b10 : 2'b01;
        if (win_flag || piece_cnt == LAST_CELL) state_next = ROUND_END;
        else                                     state_next = WAIT;
      end
      ROUND_END: begin
        buzzer_en = 1'b1;
        if (match_over)    state_next = MATCH_END;
        else if (btn_rise) state_next = CLEARING;
      end
      MATCH_END: begin
        buzzer_en = 1'b1;
      end
      default: state_next = STOPPED;
    endcase
    if (!sw_power)      state_next = STOPPED;
    else if (btn_reset) state_next = CLEARING;
  end

  // Button synchroniser, key handshake and flicker counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync  <= 2'b00;
      btn_prev  <= 1'b0;
      key_ready <= 1'b0;
      flick_cnt <= 2'd0;
    end else begin
      btn_sync  <= {btn_sync[0], btn_ok};
      btn_prev  <= btn_sync[1];
      key_ready <= key_accept;
      if (state != STARTING) flick_cnt <= 2'd0;
      else if (flicker_tick) flick_cnt <= flick_cnt + 2'd1;
    end
  end

  // Game datapath: coordinates, side, countdown, piece count and scores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x      <= '0;
      pos_y      <= '0;
      x_set      <= 1'b0;
      y_set      <= 1'b0;
      cur_side   <= 1'b0;
      first_side <= 1'b0;
      win_flag   <= 1'b0;
      piece_cnt  <= '0;
      countdown  <= '0;
      red_wins   <= '0;
      green_wins <= '0;
    end else if (!sw_power) begin
      red_wins   <= '0;
      green_wins <= '0;
    end else if (btn_reset) begin
      red_wins   <= '0;
      green_wins <= '0;
      first_side <= 1'b0;
    end else begin
      case (state)
        CLEARING: begin
          if (memrst_done) begin
            cur_side  <= first_side;
            x_set     <= 1'b0;
            y_set     <= 1'b0;
            piece_cnt <= '0;
            countdown <= CD_RELOAD;
          end
        end
        WAIT: begin
          if (timeout) begin
            cur_side  <= ~cur_side;
            x_set     <= 1'b0;
            y_set     <= 1'b0;
            countdown <= CD_RELOAD;
          end else begin
            if (sec_tick) countdown <= countdown - CD_BITS'(1);
            if (key_valid) begin
              if (key_index[EDGE_BITS]) begin
                pos_y <= key_index[EDGE_BITS-1:0];
                y_set <= 1'b1;
              end else begin
                pos_x <= key_index[EDGE_BITS-1:0];
                x_set <= 1'b1;
              end
            end
          end
        end
        JUDGE: begin
          if (judge_done) begin
            if (judge_result == 2'b01) begin
              x_set <= 1'b0;
              y_set <= 1'b0;
            end else begin
              win_flag <= (judge_result == 2'b10);
            end
          end
        end
        WRITE: begin
          if (win_flag) begin
            if (cur_side) begin
              if (green_wins != SCORE_MAX) green_wins <= green_wins + SCORE_BITS'(1);
            end else begin
              if (red_wins != SCORE_MAX) red_wins <= red_wins + SCORE_BITS'(1);
            end
          end else if (piece_cnt != LAST_CELL) begin
            piece_cnt <= piece_cnt + CNT_BITS'(1);
            cur_side  <= ~cur_side;
            x_set     <= 1'b0;
            y_set     <= 1'b0;
            countdown <= CD_RELOAD;
          end
        end
        ROUND_END: begin
          if (!match_over && btn_rise) first_side <= ~first_side;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gomoku_match_ctrl.sv
// Directed bench for gomoku_match_ctrl with hand-computed expectations.
module tb_gomoku_match_ctrl;

  localparam int EB = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw_power, btn_reset, btn_ok, sec_tick, flicker_tick;
  logic          key_valid;
  logic [EB:0]   key_index;
  logic          key_ready, memrst_en, memrst_done, judge_en, judge_done;
  logic [1:0]    judge_result;
  logic          ram_we;
  logic [2*EB-1:0] ram_wr_addr, pos;
  logic [1:0]    ram_wr_data;
  logic          cur_side, point_flicker_en, screen_flicker_en, buzzer_en;
  logic [3:0]    countdown;
  logic [1:0]    red_wins, green_wins;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gomoku_match_ctrl #(
    .EDGE_BITS(3), .MOVE_TIME(15), .CD_BITS(4), .MATCH_WINS(3), .SCORE_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_power(sw_power), .btn_reset(btn_reset),
    .btn_ok(btn_ok), .sec_tick(sec_tick), .flicker_tick(flicker_tick),
    .key_valid(key_valid), .key_index(key_index), .key_ready(key_ready),
    .memrst_en(memrst_en), .memrst_done(memrst_done), .judge_en(judge_en),
    .judge_done(judge_done), .judge_result(judge_result), .ram_we(ram_we),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .pos(pos),
    .cur_side(cur_side), .point_flicker_en(point_flicker_en),
    .screen_flicker_en(screen_flicker_en), .countdown(countdown),
    .red_wins(red_wins), .green_wins(green_wins), .buzzer_en(buzzer_en),
    .state_o(state_o)
  );

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic enter_key(input logic msb, input logic [EB-1:0] v);
    key_valid = 1'b1;
    key_index = {msb, v};
    step();
    key_valid = 1'b0;
    check_val("key_ready", key_ready, 1);
  endtask

  // Synchroniser acts on the third edge; three low cycles let it settle.
  task automatic press_ok();
    btn_ok = 1'b1;
    steps(3);
    btn_ok = 1'b0;
    steps(3);
  endtask

  task automatic clear_done();
    memrst_done = 1'b1;
    step();
    memrst_done = 1'b0;
  endtask

  // One move: keys, confirm, judge; ends after the WRITE cycle for accepted moves.
  task automatic move(input logic [EB-1:0] x, input logic [EB-1:0] y,
                      input logic [1:0] res, input logic side);
    enter_key(1'b0, x);
    enter_key(1'b1, y);
    check_val("flicker_both", point_flicker_en, 1);
    press_ok();
    check_val("judge_state", state_o, 4);
    check_val("judge_en", judge_en, 1);
    judge_result = res;
    judge_done   = 1'b1;
    step();
    judge_done   = 1'b0;
    if (res == 2'b01) begin
      check_val("inv_state", state_o, 3);
      check_val("inv_we", ram_we, 0);
    end else begin
      check_val("write_state", state_o, 5);
      check_val("write_we", ram_we, 1);
      check_val("write_addr", ram_wr_addr, {y, x});
      check_val("write_data", ram_wr_data, side ? 2 : 1);
      step();
      check_val("write_we_off", ram_we, 0);
    end
  endtask

  initial begin
    logic side;
    rst_n = 1'b0; sw_power = 1'b0; btn_reset = 1'b0; btn_ok = 1'b0;
    sec_tick = 1'b0; flicker_tick = 1'b0; key_valid = 1'b0; key_index = '0;
    memrst_done = 1'b0; judge_done = 1'b0; judge_result = 2'b00;
    steps(2);
    check_val("rst_state", state_o, 0);
    check_val("rst_countdown", countdown, 0);
    check_val("rst_side", cur_side, 0);
    check_val("rst_scores", {red_wins, green_wins}, 0);
    check_val("rst_key_ready", key_ready, 0);
    #3 rst_n = 1'b1;
    step();
    check_val("stopped_hold", state_o, 0);

    // Power-up flicker then board clear.
    sw_power = 1'b1;
    step();
    check_val("starting", state_o, 1);
    check_val("screen_flicker", screen_flicker_en, 1);
    check_val("memrst_off_start", memrst_en, 0);
    for (int i = 0; i < 3; i++) begin
      flicker_tick = 1'b1;
      step();
      flicker_tick = 1'b0;
      if (i < 2) check_val("still_starting", state_o, 1);
      step();
    end
    check_val("clearing", state_o, 2);
    check_val("memrst_on", memrst_en, 1);
    steps(63);
    check_val("clearing_hold", state_o, 2);
    clear_done();
    check_val("wait_state", state_o, 3);
    check_val("memrst_off", memrst_en, 0);
    check_val("wait_side", cur_side, 0);
    check_val("wait_countdown", countdown, 15);

    // First move: red at x=5, y=2.
    enter_key(1'b0, 3'd5);
    check_val("flicker_x_only", point_flicker_en, 0);
    enter_key(1'b1, 3'd2);
    check_val("pos_52", pos, 6'h15);
    move(3'd5, 3'd2, 2'b00, 1'b0);
    check_val("after_move_state", state_o, 3);
    check_val("after_move_side", cur_side, 1);
    check_val("after_move_cd", countdown, 15);
    check_val("after_move_flags", point_flicker_en, 0);

    // Invalid judgement returns to WAIT with the same side.
    move(3'd1, 3'd1, 2'b01, 1'b1);
    check_val("inv_side", cur_side, 1);
    check_val("inv_flags", point_flicker_en, 0);
    check_val("inv_pos", pos, 6'h09);

    // Countdown expiry with a key arriving on the timeout cycle.
    for (int i = 0; i < 15; i++) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
      if (i == 0) check_val("cd_first_dec", countdown, 14);
    end
    check_val("cd_zero", countdown, 0);
    check_val("cd_side_before", cur_side, 1);
    sec_tick = 1'b1; key_valid = 1'b1; key_index = 4'b0011;
    step();
    sec_tick = 1'b0; key_valid = 1'b0;
    check_val("timeout_side", cur_side, 0);
    check_val("timeout_reload", countdown, 15);
    check_val("timeout_no_key", key_ready, 0);
    check_val("timeout_state", state_o, 3);

    // Red wins three rounds; round two opens with green.
    move(3'd0, 3'd0, 2'b10, 1'b0);
    check_val("r1_state", state_o, 6);
    check_val("r1_red", red_wins, 1);
    check_val("r1_buzzer", buzzer_en, 1);
    press_ok();
    check_val("r2_clearing", state_o, 2);
    clear_done();
    check_val("r2_first_green", cur_side, 1);
    move(3'd1, 3'd1, 2'b00, 1'b1);
    check_val("r2_side_red", cur_side, 0);
    move(3'd2, 3'd2, 2'b10, 1'b0);
    check_val("r2_red", red_wins, 2);
    check_val("r2_green", green_wins, 0);
    press_ok();
    clear_done();
    check_val("r3_first_red", cur_side, 0);
    move(3'd3, 3'd3, 2'b10, 1'b0);
    check_val("r3_red", red_wins, 3);
    check_val("r3_round_end", state_o, 6);
    step();
    check_val("match_end", state_o, 7);
    step();
    check_val("match_hold", state_o, 7);
    check_val("match_buzzer", buzzer_en, 1);
    btn_reset = 1'b1;
    step();
    btn_reset = 1'b0;
    check_val("reset_game_state", state_o, 2);
    check_val("reset_game_red", red_wins, 0);
    clear_done();
    check_val("new_match_side", cur_side, 0);

    // Fill the whole board with valid moves: draw.
    side = 1'b0;
    for (int i = 0; i < 64; i++) begin
      move(3'(i % 8), 3'(i / 8), 2'b00, side);
      side = ~side;
      if (i < 63) check_val("fill_wait", state_o, 3);
    end
    check_val("draw_state", state_o, 6);
    check_val("draw_scores", {red_wins, green_wins}, 0);
    step();
    check_val("draw_hold", state_o, 6);

    // Power drop while judging.
    press_ok();
    clear_done();
    check_val("after_draw_side", cur_side, 1);
    enter_key(1'b0, 3'd4);
    enter_key(1'b1, 3'd4);
    press_ok();
    check_val("pd_judge", state_o, 4);
    sw_power = 1'b0;
    step();
    check_val("pd_stopped", state_o, 0);
    check_val("pd_judge_en", judge_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
